// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: holds up to DEPTH fetched packets in program order.
// Optional performance counters are compiled in when FETCH_BUF_PERF_EN is defined.
package fetch_buffer_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instruction;
        logic [XLEN-1:0] pc_plus4;
        logic            valid_if_id;
    } if_id_reg_t;
endpackage

module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  if_id_reg_t                 if_in,
    input  logic                       id_stall,
    output if_id_reg_t                 if_id_out,
    output logic                       fb_full,
    output logic [$clog2(DEPTH):0]     fb_count
`ifdef FETCH_BUF_PERF_EN
    ,
    output logic [31:0]                perf_full_cycles,
    output logic [$clog2(DEPTH):0]     perf_max_occ
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [31:0]     r_instr_mem [DEPTH];
    logic [XLEN-1:0] r_pc4_mem   [DEPTH];

    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_valid;

    // Full is decided from the registered count only, so a same-cycle pop never frees a slot.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = if_in.valid_if_id && !w_full && !flush;
    assign w_pop   = (r_count != '0) && !id_stall && !flush;
    assign w_valid = (r_count != '0) && !flush;

    assign fb_full  = w_full;
    assign fb_count = r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= if_in.pc;
            r_instr_mem[r_wr_ptr] <= if_in.instruction;
            r_pc4_mem[r_wr_ptr]   <= if_in.pc_plus4;
        end
    end

    // NOTE: every field gets a default first so the combinational output never infers a latch.
    always_comb begin
        if_id_out             = '0;
        if_id_out.instruction = NOP_INSTR;
        if (w_valid) begin
            if_id_out.pc          = r_pc_mem[r_rd_ptr];
            if_id_out.instruction = r_instr_mem[r_rd_ptr];
            if_id_out.pc_plus4    = r_pc4_mem[r_rd_ptr];
            if_id_out.valid_if_id = 1'b1;
        end
    end

`ifdef FETCH_BUF_PERF_EN
    logic [31:0]   r_perf_full_cycles;
    logic [CW-1:0] r_perf_max_occ;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_full_cycles <= '0;
            r_perf_max_occ     <= '0;
        end else begin
            if (w_full && (r_perf_full_cycles != 32'hFFFF_FFFF))
                r_perf_full_cycles <= r_perf_full_cycles + 32'd1;
            if (r_count > r_perf_max_occ)
                r_perf_max_occ <= r_count;
        end
    end

    assign perf_full_cycles = r_perf_full_cycles;
    assign perf_max_occ     = r_perf_max_occ;
`endif
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model, directed scenarios, random traffic.
// Perf counter checks are active when FETCH_BUF_PERF_EN is defined.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             id_stall;
    if_id_reg_t       if_in;
    if_id_reg_t       if_id_out;
    logic             fb_full;
    logic [CW-1:0]    fb_count;
`ifdef FETCH_BUF_PERF_EN
    logic [31:0]      perf_full_cycles;
    logic [CW-1:0]    perf_max_occ;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: program-order queue of accepted packets.
    if_id_reg_t q[$];
    bit         model_valid = 1'b0;
    longint     m_full_cycles = 0;
    int         m_max_occ = 0;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .if_in     (if_in),
        .id_stall  (id_stall),
        .if_id_out (if_id_out),
        .fb_full   (fb_full),
        .fb_count  (fb_count)
`ifdef FETCH_BUF_PERF_EN
        ,
        .perf_full_cycles (perf_full_cycles),
        .perf_max_occ     (perf_max_occ)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update at each rising edge from the inputs held during the cycle.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_full_cycles = 0;
            m_max_occ     = 0;
            model_valid   = 1'b1;
        end else if (model_valid) begin
            bit can_push;
            if (q.size() == DEPTH && m_full_cycles < 64'hFFFF_FFFF) m_full_cycles++;
            if (q.size() > m_max_occ) m_max_occ = q.size();
            if (flush) begin
                q.delete();
            end else begin
                can_push = if_in.valid_if_id && (q.size() < DEPTH);
                if (q.size() != 0 && !id_stall) void'(q.pop_front());
                if (can_push) q.push_back(if_in);
            end
        end
    end

    // Compare process: every cycle once the model is anchored by a reset.
    always @(negedge clk) begin
        if (model_valid) begin
            bit       e_valid;
            logic [31:0] e_pc, e_ins, e_pc4;
            e_valid = (q.size() != 0) && !flush;
            e_pc  = e_valid ? q[0].pc          : 32'h0;
            e_ins = e_valid ? q[0].instruction : 32'h13;
            e_pc4 = e_valid ? q[0].pc_plus4    : 32'h0;
            check("out_valid", 64'(if_id_out.valid_if_id), 64'(e_valid));
            check("out_pc",    64'(if_id_out.pc),          64'(e_pc));
            check("out_instr", 64'(if_id_out.instruction), 64'(e_ins));
            check("out_pc4",   64'(if_id_out.pc_plus4),    64'(e_pc4));
            check("fb_count",  64'(fb_count),              64'(q.size()));
            check("fb_full",   64'(fb_full),               64'(q.size() == DEPTH));
`ifdef FETCH_BUF_PERF_EN
            check("perf_full_cycles", 64'(perf_full_cycles), 64'(m_full_cycles));
            check("perf_max_occ",     64'(perf_max_occ),     64'(m_max_occ));
`endif
        end
    end

    task automatic apply(input logic rst, input logic fl, input logic st,
                         input logic v, input logic [31:0] pc);
        @(posedge clk);
        #1;
        reset                 = rst;
        flush                 = fl;
        id_stall              = st;
        if_in.valid_if_id     = v;
        if_in.pc              = pc;
        if_in.pc_plus4        = pc + 32'd4;
        if_in.instruction     = $urandom;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        id_stall = 1'b0;
        if_in = '0;

        // Reset then fill
        apply(1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        probe();
        check("rst_valid", 64'(if_id_out.valid_if_id), 64'd0);
        check("rst_instr", 64'(if_id_out.instruction), 64'h13);
        check("rst_count", 64'(fb_count), 64'd0);
        check("rst_full",  64'(fb_full), 64'd0);
        for (int i = 0; i < 4; i++) apply(0, 0, 1, 1, 32'(i * 4));
        apply(0, 0, 1, 1, 32'h10);
        probe();
        check("fill_count", 64'(fb_count), 64'd4);
        check("fill_full",  64'(fb_full), 64'd1);
        check("fill_head",  64'(if_id_out.pc), 64'h0);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 0);
            probe();
            check("drain_pc", 64'(if_id_out.pc), 64'(i * 4));
        end
        apply(0, 0, 0, 0, 0);
        probe();
        check("drain_empty_valid", 64'(if_id_out.valid_if_id), 64'd0);
        check("drain_empty_instr", 64'(if_id_out.instruction), 64'h13);

        // Streaming, wraps the pointers
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 0, 1, 32'h100 + 32'(i * 4));
            probe();
            if (i > 0) begin
                check("stream_count", 64'(fb_count), 64'd1);
                check("stream_pc", 64'(if_id_out.pc), 64'(32'h100 + 32'((i - 1) * 4)));
            end
        end
        apply(0, 0, 0, 0, 0);

        // Flush with a concurrent push
        for (int i = 0; i < 3; i++) apply(0, 0, 1, 1, 32'h40 + 32'(i * 4));
        apply(0, 1, 1, 1, 32'h20);
        probe();
        check("flush_valid", 64'(if_id_out.valid_if_id), 64'd0);
        apply(0, 0, 0, 0, 0);
        probe();
        check("flush_count", 64'(fb_count), 64'd0);
        check("flush_no_0x20", 64'(if_id_out.valid_if_id), 64'd0);

        // Full boundary with pop and concurrent push
        for (int i = 0; i < 4; i++) apply(0, 0, 1, 1, 32'h50 + 32'(i * 4));
        apply(0, 0, 0, 1, 32'h60);
        probe();
        check("bnd_full", 64'(fb_full), 64'd1);
        apply(0, 0, 1, 1, 32'h60);
        probe();
        check("bnd_count3", 64'(fb_count), 64'd3);
        check("bnd_head", 64'(if_id_out.pc), 64'h54);
        apply(0, 0, 1, 0, 0);
        probe();
        check("bnd_count4", 64'(fb_count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 0);
            probe();
            check("bnd_drain_pc", 64'(if_id_out.pc), 64'(32'h54 + 32'(i * 4)));
        end

        // Mid-operation reset beats flush and push
        apply(0, 0, 1, 1, 32'h70);
        apply(0, 0, 1, 1, 32'h74);
        apply(1, 1, 0, 1, 32'h78);
        apply(0, 0, 1, 0, 0);
        probe();
        check("midrst_count", 64'(fb_count), 64'd0);
        check("midrst_valid", 64'(if_id_out.valid_if_id), 64'd0);

`ifdef FETCH_BUF_PERF_EN
        // Hold full for 7 cycles, the last being a flush
        for (int i = 0; i < 4; i++) apply(0, 0, 1, 1, 32'h80 + 32'(i * 4));
        for (int i = 0; i < 6; i++) apply(0, 0, 1, 0, 0);
        apply(0, 1, 1, 1, 32'h90);
        probe();
        check("perf_pre_flush", 64'(perf_full_cycles), 64'd6);
        apply(0, 0, 1, 0, 0);
        probe();
        check("perf_full7", 64'(perf_full_cycles), 64'd7);
        check("perf_max4", 64'(perf_max_occ), 64'd4);
        apply(0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        probe();
        check("perf_hold_full", 64'(perf_full_cycles), 64'd7);
        check("perf_hold_max", 64'(perf_max_occ), 64'd4);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 99) < 5),
                  ($urandom_range(0, 99) < 40),
                  ($urandom_range(0, 99) < 70),
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
        end
        apply(0, 0, 0, 0, 0);
        probe();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
